spi_flash_responder: RTL and testbench

- Behavioural SPI NOR-flash target for the SoC testbench.
- Attaches to the opposite end of the SoC's SPI host pins:
  - decodes chip-select, clock and MOSI driven by the DUT;
  - returns read data on MISO from an internal byte array, preloaded by the bench.
- Oversamples the SPI pins on the system clock and supports SPI mode 0, single-lane.
- Lets boot-from-flash and SPI driver tests run without an external flash model.

---
 rtl/spi_flash_resp_pkg.sv | 41 ++++
 rtl/spi_flash_resp_sync.sv | 48 ++++
 rtl/spi_flash_responder.sv | 206 ++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_resp_pkg
// Purpose  : Shared opcodes, FSM state encoding and opcode helpers for the
//            behavioural SPI NOR-flash responder.
// Options  : SPI_FLASH_RESP_PROG_EN - adds PAGE PROGRAM (0x02) support.
// Revision : 1.0 - initial release
// ============================================================================
package spi_flash_resp_pkg;

    localparam logic [7:0] OpRead = 8'h03;
    localparam logic [7:0] OpRdsr = 8'h05;
    localparam logic [7:0] OpRdid = 8'h9F;
    localparam logic [7:0] OpProg = 8'h02;

    localparam int AddrBits = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        DATA   = 3'd3,
        IGNORE = 3'd4
    } state_t;

    // Opcodes that are followed by a 24-bit address phase.
    function automatic logic op_has_addr(input logic [7:0] op);
`ifdef SPI_FLASH_RESP_PROG_EN
        return (op == OpRead) || (op == OpProg);
`else
        return (op == OpRead);
`endif
    endfunction

    // Opcodes that go straight from the command byte into a data phase.
    function automatic logic op_no_addr(input logic [7:0] op);
        return (op == OpRdsr) || (op == OpRdid);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_flash_resp_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_resp_sync
// Purpose  : Two-flop synchronizer for a group of level-only pins plus one
//            edge-detected pin (rise/fall from synced value vs. 1-cycle delay).
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_resp_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_edge_pin,
    input  logic [WIDTH-1:0] i_level_pins,
    output logic [WIDTH-1:0] o_level_sync,
    output logic             o_rise,
    output logic             o_fall
);

    logic [WIDTH-1:0] r_lvl_meta;
    logic [WIDTH-1:0] r_lvl_sync;
    logic             r_edge_meta;
    logic             r_edge_sync;
    logic             r_edge_dly;

    // Clears to 0 so a chip select held low through reset never looks like a fresh fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl_meta  <= '0;
            r_lvl_sync  <= '0;
            r_edge_meta <= 1'b0;
            r_edge_sync <= 1'b0;
            r_edge_dly  <= 1'b0;
        end else begin
            r_lvl_meta  <= i_level_pins;
            r_lvl_sync  <= r_lvl_meta;
            r_edge_meta <= i_edge_pin;
            r_edge_sync <= r_edge_meta;
            r_edge_dly  <= r_edge_sync;
        end
    end

    assign o_level_sync = r_lvl_sync;
    assign o_rise       = r_edge_sync & ~r_edge_dly;
    assign o_fall       = ~r_edge_sync & r_edge_dly;

endmodule
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : Oversampled SPI mode-0 single-lane NOR-flash target. Serves
//            READ / RDSR / RDID from a bench-preloaded byte array.
// Options  : SPI_FLASH_RESP_PROG_EN - accept PAGE PROGRAM (0x02) writes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder
    import spi_flash_resp_pkg::*;
#(
    parameter int          MemBytes = 1024,
    parameter logic [23:0] JedecId  = 24'hEF4018
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        spi_sck_i,
    input  logic                        spi_csb_i,
    input  logic                        spi_sd_i,
    output logic                        spi_sd_o,
    output logic                        spi_sd_oe_o,
    input  logic                        mem_we_i,
    input  logic [$clog2(MemBytes)-1:0] mem_addr_i,
    input  logic [7:0]                  mem_wdata_i,
    output logic                        busy_o,
    output logic                        err_o
);

    localparam int c_aw = $clog2(MemBytes);

    logic [7:0]          r_mem [MemBytes];
    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_err_nxt;
    logic [1:0]          w_lvl_s;
    logic                w_sd_s;
    logic                w_csb_s;
    logic                w_sck_rise;
    logic                w_sck_fall;
    logic                r_csb_d;
    logic                w_csb_fall;
    logic [4:0]          r_bitcnt;
    logic [22:0]         r_shift;
    logic [7:0]          w_rx_byte;
    logic [AddrBits-1:0] w_rx_addr;
    logic [7:0]          r_opcode;
    logic [c_aw-1:0]     r_addr;
    logic [c_aw-1:0]     w_addr_inc;
    logic [7:0]          r_tx;
    logic [7:0]          w_next_byte;
    logic [1:0]          r_id_idx;
    logic                r_sd_o;
    logic                r_oe;
    logic                r_err;
    logic                w_prog_mode;
    logic                w_prog_we;
    logic                w_unused_addr_hi;

    spi_flash_resp_sync #(.WIDTH(2)) u_sync (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_edge_pin   (spi_sck_i),
        .i_level_pins ({spi_sd_i, spi_csb_i}),
        .o_level_sync (w_lvl_s),
        .o_rise       (w_sck_rise),
        .o_fall       (w_sck_fall)
    );

    assign w_csb_s          = w_lvl_s[0];
    assign w_sd_s           = w_lvl_s[1];
    assign w_csb_fall       = r_csb_d & ~w_csb_s;
    assign w_rx_byte        = {r_shift[6:0], w_sd_s};
    assign w_rx_addr        = {r_shift, w_sd_s};
    assign w_addr_inc       = r_addr + c_aw'(1);
    assign w_unused_addr_hi = ^w_rx_addr[AddrBits-1:c_aw];

`ifdef SPI_FLASH_RESP_PROG_EN
    assign w_prog_mode = (r_opcode == OpProg);
`else
    assign w_prog_mode = 1'b0;
`endif

    assign w_prog_we = (r_state == DATA) && w_prog_mode && w_sck_rise &&
                       (r_bitcnt == 5'd7) && !w_csb_s && !rst_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode and the unsupported-opcode error strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: if (w_csb_fall) w_state_nxt = CMD;
            CMD: if (w_sck_rise && r_bitcnt == 5'd7) begin
                if (op_has_addr(w_rx_byte))      w_state_nxt = ADDR;
                else if (op_no_addr(w_rx_byte))  w_state_nxt = DATA;
                else begin
                    w_state_nxt = IGNORE;
                    w_err_nxt   = 1'b1;
                end
            end
            ADDR: if (w_sck_rise && r_bitcnt == 5'd23) w_state_nxt = DATA;
            default: ;
        endcase
        if (w_csb_s && r_state != IDLE) begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b0;
        end
    end

    // Byte to present after the current one: RDID walks the ID then pads zeros.
    always_comb begin
        w_next_byte = 8'h00;
        if (r_opcode == OpRdid) begin
            case (r_id_idx)
                2'd1:    w_next_byte = JedecId[15:8];
                2'd2:    w_next_byte = JedecId[7:0];
                default: w_next_byte = 8'h00;
            endcase
        end else if (r_opcode != OpRdsr) begin
            w_next_byte = r_mem[w_addr_inc];
        end
    end

    // Shift/count datapath; CS high or IDLE discards partial bytes and drops oe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_csb_d  <= 1'b0;
            r_bitcnt <= 5'd0;
            r_shift  <= '0;
            r_opcode <= 8'h00;
            r_addr   <= '0;
            r_tx     <= 8'h00;
            r_id_idx <= 2'd0;
            r_sd_o   <= 1'b0;
            r_oe     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_csb_d <= w_csb_s;
            r_err   <= w_err_nxt;
            if (w_csb_s || r_state == IDLE) begin
                r_bitcnt <= 5'd0;
                r_oe     <= 1'b0;
            end else begin
                case (r_state)
                    CMD, ADDR: if (w_sck_rise) begin
                        r_shift  <= w_rx_addr[22:0];
                        r_bitcnt <= r_bitcnt + 5'd1;
                        if (r_state == CMD && r_bitcnt == 5'd7) begin
                            r_bitcnt <= 5'd0;
                            r_opcode <= w_rx_byte;
                            r_id_idx <= 2'd1;
                            r_tx     <= (w_rx_byte == OpRdid) ? JedecId[23:16] : 8'h00;
                        end
                        if (r_state == ADDR && r_bitcnt == 5'd23) begin
                            r_bitcnt <= 5'd0;
                            r_addr   <= w_rx_addr[c_aw-1:0];
                            r_tx     <= r_mem[w_rx_addr[c_aw-1:0]];
                        end
                    end
                    DATA: if (w_prog_mode) begin
                        if (w_sck_rise) begin
                            r_shift <= w_rx_addr[22:0];
                            if (r_bitcnt == 5'd7) begin
                                r_bitcnt <= 5'd0;
                                r_addr   <= w_addr_inc;
                            end else begin
                                r_bitcnt <= r_bitcnt + 5'd1;
                            end
                        end
                    end else if (w_sck_fall) begin
                        r_sd_o <= r_tx[7];
                        r_oe   <= 1'b1;
                        r_tx   <= {r_tx[6:0], 1'b0};
                        if (r_bitcnt == 5'd7) begin
                            r_bitcnt <= 5'd0;
                            r_addr   <= w_addr_inc;
                            r_tx     <= w_next_byte;
                            if (r_id_idx != 2'd3) r_id_idx <= r_id_idx + 2'd1;
                        end else begin
                            r_bitcnt <= r_bitcnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte array: programmed bytes first so a same-address preload wins.
    always_ff @(posedge clk_i) begin
        if (w_prog_we) r_mem[r_addr] <= w_rx_byte;
        if (mem_we_i)  r_mem[mem_addr_i] <= mem_wdata_i;
    end

    assign spi_sd_o    = r_sd_o;
    assign spi_sd_oe_o = r_oe;
    assign busy_o      = (r_state != IDLE);
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Self-checking bench: SPI mode-0 host driving the responder, with
//            expected MISO bytes queued per command and checked on receipt.
// Options  : SPI_FLASH_RESP_PROG_EN - selects the PAGE PROGRAM expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       csb = 1'b1;
    logic       mosi = 1'b0;
    logic       we = 1'b0;
    logic [9:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic       miso;
    logic       oe;
    logic       busy;
    logic       err;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];

    spi_flash_responder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .spi_sck_i   (sck),
        .spi_csb_i   (csb),
        .spi_sd_i    (mosi),
        .spi_sd_o    (miso),
        .spi_sd_oe_o (oe),
        .mem_we_i    (we),
        .mem_addr_i  (waddr),
        .mem_wdata_i (wdata),
        .busy_o      (busy),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Counts cycles with err_o high; a clean pulse adds exactly one.
    always @(negedge clk) if (err === 1'b1) err_cnt++;

    task automatic preload(input int a, input logic [7:0] d);
        @(negedge clk);
        waddr = a[9:0];
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic oe_all, output logic oe_any);
        rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i]  = miso;
            oe_all = oe_all & oe;
            oe_any = oe_any | oe;
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        csb = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        csb = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr,
                            input bit with_addr, output logic oe_seen);
        logic [7:0] rx;
        logic       a, o;
        spi_bits(op, 8, rx, a, o);
        oe_seen = o;
        if (with_addr) begin
            for (int b = 2; b >= 0; b--) begin
                spi_bits(addr[b*8 +: 8], 8, rx, a, o);
                oe_seen = oe_seen | o;
            end
        end
    endtask

    // Scoreboard receive side: clocks bytes out and compares against the queue.
    task automatic recv_bytes(input string name, input int n);
        logic [7:0] rx, e;
        logic       all_oe, any_oe;
        for (int k = 0; k < n; k++) begin
            spi_bits(8'h00, 8, rx, all_oe, any_oe);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s byte%0d: got %h, nothing expected", name, k, rx);
            end else begin
                e = exp_q.pop_front();
                if (rx !== e) begin
                    n_bad++;
                    $display("FAIL %s byte%0d: got %h expected %h", name, k, rx, e);
                end
            end
            n_cmp++;
            if (all_oe !== 1'b1) begin
                n_bad++;
                $display("FAIL %s oe byte%0d: got %b expected 1", name, k, all_oe);
            end
        end
    endtask

    task automatic do_read(input string name, input logic [23:0] addr, input int n);
        logic o;
        cs_begin();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy: got %b expected 1", name, busy); end
        send_hdr(8'h03, addr, 1'b1, o);
        n_cmp++;
        if (o !== 1'b0) begin n_bad++; $display("FAIL %s hdr oe: got %b expected 0", name, o); end
        recv_bytes(name, n);
        cs_end();
        n_cmp++;
        if (busy !== 1'b0 || oe !== 1'b0) begin
            n_bad++; $display("FAIL %s idle: got busy=%b oe=%b expected 0 0", name, busy, oe);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL %s leftover: got %0d expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({miso, oe, busy, err} !== 4'b0000) begin
            n_bad++; $display("FAIL reset: got sd=%b oe=%b busy=%b err=%b expected 0 0 0 0", miso, oe, busy, err);
        end
    endtask

    task automatic test_read();
        preload(16'h010, 8'hDE); preload(16'h011, 8'hAD);
        preload(16'h012, 8'hBE); preload(16'h013, 8'hEF);
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD);
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        do_read("read4", 24'h000010, 4);
    endtask

    task automatic test_wrap();
        preload(1023, 8'h11); preload(0, 8'h22);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        do_read("wrap", 24'h0003FF, 2);
    endtask

    task automatic test_id_status();
        logic o;
        exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
        exp_q.push_back(8'h18); exp_q.push_back(8'h00);
        cs_begin();
        send_hdr(8'h9F, 24'h0, 1'b0, o);
        recv_bytes("rdid", 4);
        cs_end();
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        cs_begin();
        send_hdr(8'h05, 24'h0, 1'b0, o);
        recv_bytes("rdsr", 2);
        cs_end();
    endtask

    task automatic test_bad_opcode();
        logic [7:0] rx;
        logic       a, o1, o2;
        int         e0;
        e0 = err_cnt;
        cs_begin();
        spi_bits(8'hAB, 8, rx, a, o1);
        spi_bits(8'h00, 8, rx, a, o2);
        n_cmp++;
        if ((o1 | o2) !== 1'b0) begin n_bad++; $display("FAIL badop oe: got 1 expected 0"); end
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL badop busy: got %b expected 1", busy); end
        n_cmp++;
        if (err_cnt - e0 != 1) begin
            n_bad++; $display("FAIL badop err cycles: got %0d expected 1", err_cnt - e0);
        end
        cs_end();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL badop busy end: got %b expected 0", busy); end
        exp_q.push_back(8'hDE);
        do_read("after_badop", 24'h000010, 1);
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        logic       a, o;
        preload(4, 8'h5A); preload(5, 8'h6B);
        cs_begin();
        spi_bits(8'h03, 8, rx, a, o);
        spi_bits(8'h00, 8, rx, a, o);
        spi_bits(8'h00, 5, rx, a, o);
        cs_end();
        exp_q.push_back(8'h5A); exp_q.push_back(8'h6B);
        do_read("after_abort", 24'h000004, 2);
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        logic       a, o;
        cs_begin();
        send_hdr(8'h03, 24'h000010, 1'b1, o);
        spi_bits(8'h00, 4, rx, a, o);
        n_cmp++;
        if (a !== 1'b1) begin n_bad++; $display("FAIL rstmid pre oe: got %b expected 1", a); end
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        n_cmp++;
        if (oe !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid: got oe=%b busy=%b expected 0 0", oe, busy);
        end
        spi_bits(8'h00, 8, rx, a, o);
        n_cmp++;
        if (o !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rstmid held cs: got oe=%b busy=%b expected 0 0", o, busy);
        end
        cs_end();
        exp_q.push_back(8'hBE);
        do_read("after_rstmid", 24'h000012, 1);
    endtask

    task automatic test_prog();
        logic [7:0] rx;
        logic       a, o, oh;
        int         e0;
`ifndef SPI_FLASH_RESP_PROG_EN
        preload(16'h020, 8'h31); preload(16'h021, 8'h32);
`endif
        e0 = err_cnt;
        cs_begin();
        send_hdr(8'h02, 24'h000020, 1'b1, oh);
        spi_bits(8'h55, 8, rx, a, o);
        oh = oh | o;
        spi_bits(8'hAA, 8, rx, a, o);
        oh = oh | o;
        cs_end();
        n_cmp++;
        if (oh !== 1'b0) begin n_bad++; $display("FAIL prog oe: got %b expected 0", oh); end
`ifdef SPI_FLASH_RESP_PROG_EN
        n_cmp++;
        if (err_cnt - e0 != 0) begin
            n_bad++; $display("FAIL prog err cycles: got %0d expected 0", err_cnt - e0);
        end
        exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
`else
        n_cmp++;
        if (err_cnt - e0 != 1) begin
            n_bad++; $display("FAIL prog err cycles: got %0d expected 1", err_cnt - e0);
        end
        exp_q.push_back(8'h31); exp_q.push_back(8'h32);
`endif
        do_read("prog_readback", 24'h000020, 2);
    endtask

    initial begin
        test_reset();
        test_read();
        test_wrap();
        test_id_status();
        test_bad_opcode();
        test_abort();
        test_reset_mid();
        test_prog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
